// File: rtl/lc3_pkg.sv
// Shared encodings and fixed-point helpers for the
// LC3plus decoder time-domain synthesis path.
package lc3_pkg;

    localparam int          MAX_N_DEF    = 1024;
    localparam logic [11:0] WIN_BASE_DEF = 12'h000;
    localparam logic [11:0] OVL_BASE_DEF = 12'h800;

    localparam logic [1:0] SW_16 = 2'b00;
    localparam logic [1:0] SW_24 = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_FETCH,
        S_CALC,
        S_EMIT,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        PH_FIRST  = 2'd0,
        PH_SECOND = 2'd1
    } phase_t;

    function automatic logic signed [63:0] sx24(input logic [23:0] v);
        return signed'({{40{v[23]}}, v});
    endfunction

    function automatic logic signed [63:0] rnd_shift(
        input logic signed [63:0] v,
        input int                 sh
    );
        logic signed [63:0] r;
        r = v + (64'sd1 <<< (sh - 1));
        return r >>> sh;
    endfunction

    function automatic logic [23:0] sat24(input logic signed [63:0] v);
        if (v > 64'sd8388607)
            return 24'h7FFFFF;
        if (v < -64'sd8388608)
            return 24'h800000;
        return v[23:0];
    endfunction

    function automatic logic [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767)
            return 16'h7FFF;
        if (v < -64'sd32768)
            return 16'h8000;
        return v[15:0];
    endfunction

endpackage

// File: rtl/tds_mac.sv
// Signed multiply, round-shift, accumulate and 24-bit clamp;
// shared by the window multiply and the de-emphasis tap.
module tds_mac
    import lc3_pkg::*;
#(
    parameter int SHIFT = 31
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [23:0] acc,
    output logic [23:0] y
);

    logic signed [63:0] prod;

    assign prod = signed'({{32{a[31]}}, a}) * signed'({{32{b[31]}}, b});
    assign y    = sat24(sx24(acc) + rnd_shift(prod, SHIFT));

endmodule

// File: rtl/time_domain_synth.sv
// Decoder time-domain synthesis: window, overlap-add with the
// previous tail, de-emphasis and saturated PCM streaming.
module time_domain_synth
    import lc3_pkg::*;
#(
    parameter int          MAX_N    = MAX_N_DEF,
    parameter logic [11:0] WIN_BASE = WIN_BASE_DEF,
    parameter logic [11:0] OVL_BASE = OVL_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic        clear_state,
    output logic        done,
    output logic        error,
    input  logic [15:0] frame_length,
    input  logic [1:0]  sample_width,
    input  logic [15:0] deemph_coeff,
    input  logic [23:0] time_data,
    input  logic        time_valid,
    output logic        time_ready,
    output logic [31:0] pcm_data,
    output logic        pcm_valid,
    input  logic        pcm_ready,
    output logic [11:0] coeff_addr,
    output logic        coeff_ren,
    input  logic [31:0] coeff_data,
    output logic [11:0] ovl_addr,
    output logic [31:0] ovl_wdata,
    input  logic [31:0] ovl_rdata,
    output logic        ovl_wen,
    output logic        ovl_ren,
    output logic [31:0] debug_status
);

    localparam logic [15:0] MAX_N16 = 16'(MAX_N);

    state_t      state;
    phase_t      phase;
    logic [13:0] idx, n_q, rel;
    logic        width_q;
    logic [15:0] alpha_q;
    logic [23:0] x_q, deemph_mem;
    logic        ovl_valid;
    logic        second, last, bad_cfg, abort;
    logic [23:0] ovl_term, w, s, y;
    logic [15:0] p16;
    logic [31:0] pcm_next;
    logic        unused_ok;

    assign second   = (state != S_IDLE) && (idx >= n_q);
    assign phase    = second ? PH_SECOND : PH_FIRST;
    assign last     = (idx == ((n_q << 1) - 14'd1));
    assign rel      = idx - n_q;
    assign abort    = (state != S_IDLE) && !enable;
    assign bad_cfg  = (frame_length == 16'd0)
                   || (frame_length > MAX_N16)
                   || (sample_width > SW_24);

    assign ovl_term = ovl_valid ? ovl_rdata[23:0] : 24'h0;
    assign s        = sat24(sx24(w) + sx24(ovl_term));
    assign p16      = sat16(rnd_shift(sx24(y), 8));
    assign pcm_next = width_q ? {{8{y[23]}}, y}
                              : {{16{p16[15]}}, p16};
    assign unused_ok = ^ovl_rdata[31:24];

    assign debug_status = {8'h00, state, phase, ovl_valid, 4'h0, idx};

    tds_mac #(.SHIFT(31)) u_win (
        .a   ({{8{x_q[23]}}, x_q}),
        .b   (coeff_data),
        .acc (24'h0),
        .y   (w)
    );

    tds_mac #(.SHIFT(15)) u_demph (
        .a   ({{16{alpha_q[15]}}, alpha_q}),
        .b   ({{8{deemph_mem[23]}}, deemph_mem}),
        .acc (s),
        .y   (y)
    );

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state      <= S_IDLE;
            idx        <= '0;
            ovl_valid  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            time_ready <= 1'b0;
            pcm_data   <= '0;
            pcm_valid  <= 1'b0;
            coeff_addr <= '0;
            coeff_ren  <= 1'b0;
            ovl_addr   <= '0;
            ovl_wdata  <= '0;
            ovl_wen    <= 1'b0;
            ovl_ren    <= 1'b0;
            if (rst) begin
                deemph_mem <= '0;
                n_q        <= '0;
                width_q    <= 1'b0;
                alpha_q    <= '0;
                x_q        <= '0;
            end
        end else begin
            done      <= 1'b0;
            error     <= 1'b0;
            coeff_ren <= 1'b0;
            ovl_ren   <= 1'b0;
            ovl_wen   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // clear first so a same-cycle start sees a fresh state
                    if (clear_state) begin
                        ovl_valid  <= 1'b0;
                        deemph_mem <= '0;
                    end
                    if (start && enable) begin
                        if (bad_cfg) begin
                            error <= 1'b1;
                        end else begin
                            n_q        <= frame_length[13:0];
                            width_q    <= (sample_width == SW_24);
                            alpha_q    <= deemph_coeff;
                            idx        <= '0;
                            time_ready <= 1'b1;
                            state      <= S_ACCEPT;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (time_valid) begin
                        x_q        <= time_data;
                        time_ready <= 1'b0;
                        coeff_ren  <= 1'b1;
                        coeff_addr <= WIN_BASE + idx[11:0];
                        if (!second && ovl_valid) begin
                            ovl_ren  <= 1'b1;
                            ovl_addr <= OVL_BASE + idx[11:0];
                        end
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_CALC;
                S_CALC: begin
                    idx <= idx + 14'd1;
                    if (!second) begin
                        deemph_mem <= y;
                        pcm_data   <= pcm_next;
                        pcm_valid  <= 1'b1;
                        state      <= S_EMIT;
                    end else begin
                        ovl_wen   <= 1'b1;
                        ovl_addr  <= OVL_BASE + rel[11:0];
                        ovl_wdata <= {8'h00, w};
                        if (last) begin
                            state <= S_FINISH;
                        end else begin
                            time_ready <= 1'b1;
                            state      <= S_ACCEPT;
                        end
                    end
                end
                S_EMIT: begin
                    if (pcm_ready) begin
                        pcm_valid  <= 1'b0;
                        time_ready <= 1'b1;
                        state      <= S_ACCEPT;
                    end
                end
                S_FINISH: begin
                    ovl_valid <= 1'b1;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_domain_synth.sv
// Directed scoreboard bench for time_domain_synth: window,
// overlap-add, de-emphasis, saturation, backpressure and aborts.
module tb_time_domain_synth;

    localparam logic [11:0] OVL_BASE = 12'h800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        clear_state = 1'b0;
    logic [15:0] frame_length = 16'd4;
    logic [1:0]  sample_width = 2'b01;
    logic [15:0] deemph_coeff = 16'h0;
    logic [23:0] time_data = 24'h0;
    logic        time_valid = 1'b0;
    logic        pcm_ready = 1'b1;
    logic        done, error, time_ready, pcm_valid;
    logic        coeff_ren, ovl_wen, ovl_ren;
    logic [31:0] pcm_data, coeff_data, ovl_wdata, ovl_rdata;
    logic [31:0] debug_status, hold;
    logic [11:0] coeff_addr, ovl_addr;
    logic [126:0] all_out;

    logic [31:0] rom [0:4095];
    logic [31:0] ovl_mem [0:4095];
    logic [23:0] xbuf [0:2047];
    logic [31:0] pcm_q [$];
    logic [43:0] wr_q [$];
    longint      m_ovl [0:1023];
    bit          m_valid, cur_w24;
    longint      m_mem, cur_alpha;
    int          cur_n;
    int          vectors = 0;
    int          miscompares = 0;

    time_domain_synth dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .start        (start),
        .clear_state  (clear_state),
        .done         (done),
        .error        (error),
        .frame_length (frame_length),
        .sample_width (sample_width),
        .deemph_coeff (deemph_coeff),
        .time_data    (time_data),
        .time_valid   (time_valid),
        .time_ready   (time_ready),
        .pcm_data     (pcm_data),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .coeff_addr   (coeff_addr),
        .coeff_ren    (coeff_ren),
        .coeff_data   (coeff_data),
        .ovl_addr     (ovl_addr),
        .ovl_wdata    (ovl_wdata),
        .ovl_rdata    (ovl_rdata),
        .ovl_wen      (ovl_wen),
        .ovl_ren      (ovl_ren),
        .debug_status (debug_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (coeff_ren) coeff_data <= rom[coeff_addr];
        if (ovl_ren) ovl_rdata <= ovl_mem[ovl_addr];
        if (ovl_wen) ovl_mem[ovl_addr] <= ovl_wdata;
    end

    assign all_out = {done, error, time_ready, pcm_valid, pcm_data,
                      coeff_ren, coeff_addr, ovl_ren, ovl_wen,
                      ovl_addr, ovl_wdata, debug_status};

    function automatic longint rs(input longint v, input int sh);
        return (v + (longint'(1) << (sh - 1))) >>> sh;
    endfunction

    function automatic longint clamp(input longint v, input longint lo,
                                     input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        vectors++;
        assert (all_out === '0) else begin
            miscompares++;
            $error("FAIL %s: outputs %h, want all zero", tag, all_out);
        end
    endtask

    task automatic abort_model();
        pcm_q.delete();
        wr_q.delete();
        m_valid = 1'b0;
    endtask

    task automatic start_frame(input int n, input bit w24,
                               input logic [15:0] a);
        frame_length = 16'(n);
        sample_width = w24 ? 2'b01 : 2'b00;
        deemph_coeff = a;
        cur_n     = n;
        cur_w24   = w24;
        cur_alpha = longint'($signed(a));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [23:0] x, input int i);
        longint xv, c, w, s, y, p;
        logic [31:0] exp_pcm;
        logic [43:0] exp_wr;
        int k;
        xv = $signed(x);
        c  = $signed(rom[i]);
        w  = clamp(rs(xv * c, 31), -8388608, 8388607);
        if (i < cur_n) begin
            s = clamp(w + (m_valid ? m_ovl[i] : 0), -8388608, 8388607);
            y = clamp(s + rs(cur_alpha * m_mem, 15), -8388608, 8388607);
            m_mem = y;
            p = cur_w24 ? y : clamp(rs(y, 8), -32768, 32767);
            pcm_q.push_back(32'(p));
        end else begin
            wr_q.push_back({OVL_BASE + 12'(i - cur_n), 8'h00, 24'(w)});
            m_ovl[i - cur_n] = w;
        end
        time_data  = x;
        time_valid = 1'b1;
        k = 0;
        while (time_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept", time_ready, 1);
        @(posedge clk);
        #1 time_valid = 1'b0;
        k = 0;
        if (i < cur_n) begin
            while (pcm_valid !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            exp_pcm = (pcm_q.size() > 0) ? pcm_q.pop_front() : 32'hX;
            chk("pcm", {pcm_valid, pcm_data}, {1'b1, exp_pcm});
        end else begin
            while (ovl_wen !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            exp_wr = (wr_q.size() > 0) ? wr_q.pop_front() : 44'hX;
            chk("ovl_wr", {ovl_wen, ovl_addr, ovl_wdata}, {1'b1, exp_wr});
        end
    endtask

    task automatic finish_frame();
        int k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("done", done, 1);
        chk("sb_empty", pcm_q.size() + wr_q.size(), 0);
        m_valid = 1'b1;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic run_frame(input int n, input bit w24,
                             input logic [15:0] a);
        start_frame(n, w24, a);
        for (int i = 0; i < 2 * n; i++) send(xbuf[i], i);
        finish_frame();
    endtask

    task automatic bad_start(input logic [15:0] len, input logic [1:0] sw);
        frame_length = len;
        sample_width = sw;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("err_pulse", {error, time_ready, debug_status[23:21]}, 5'b10000);
        @(negedge clk);
        chk("err_clear", {error, time_ready}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'h7FFFFFFF;
        m_valid = 1'b0;
        m_mem   = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        for (int i = 0; i < 8; i++) xbuf[i] = 24'h100000;
        run_frame(4, 1'b1, 16'h0);
        run_frame(4, 1'b1, 16'h0);

        start_frame(4, 1'b1, 16'h0);
        pcm_ready = 1'b0;
        send(xbuf[0], 0);
        hold = pcm_data;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", {pcm_valid, time_ready, coeff_ren, ovl_ren,
                            ovl_wen, pcm_data}, {5'b10000, hold});
        end
        pcm_ready = 1'b1;
        for (int i = 1; i < 8; i++) send(xbuf[i], i);
        finish_frame();

        start_frame(4, 1'b1, 16'h0);
        pcm_ready = 1'b0;
        send(xbuf[0], 0);
        enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        chk_zero("en_abort");
        abort_model();
        pcm_ready = 1'b1;
        run_frame(4, 1'b1, 16'h0);

        start_frame(1024, 1'b1, 16'h0);
        @(negedge clk);
        chk("maxn_accept", time_ready, 1);
        enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        chk_zero("maxn_abort");
        abort_model();

        clear_state = 1'b1;
        @(posedge clk);
        #1 clear_state = 1'b0;
        m_valid = 1'b0;
        m_mem   = 0;
        for (int i = 0; i < 8; i++) xbuf[i] = 24'h0;
        xbuf[0] = 24'h400000;
        run_frame(4, 1'b1, 16'h4000);

        for (int i = 0; i < 8; i++) xbuf[i] = 24'h7FFFFF;
        run_frame(4, 1'b0, 16'h0);
        run_frame(4, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) xbuf[i] = 24'h800000;
        run_frame(4, 1'b0, 16'h0);
        run_frame(4, 1'b0, 16'h0);

        for (int i = 0; i < 16; i++) begin
            rom[i]  = $urandom;
            xbuf[i] = 24'($urandom);
        end
        run_frame(8, 1'b1, 16'hA000);
        run_frame(8, 1'b0, 16'h6000);

        start_frame(8, 1'b1, 16'h0);
        for (int i = 0; i < 3; i++) send(xbuf[i], i);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_abort");
        abort_model();
        m_mem = 0;
        for (int i = 0; i < 16; i++) begin
            rom[i]  = 32'h7FFFFFFF;
            xbuf[i] = 24'h100000;
        end
        run_frame(4, 1'b1, 16'h0);

        bad_start(16'd0, 2'b01);
        bad_start(16'd4, 2'b10);
        bad_start(16'd1025, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
